// File: rtl/kpn_pkg.sv
// rtl/kpn_pkg.sv - shared types and defaults for KPN compute nodes
package kpn_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int COUNT_W_DEF = 8;

  // Node FSM encoding, shared by every node that consumes queue_module channels
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } node_state_t;

  // Queue channel bundle naming: <q>_empty/<q>_rd/<q>_data on the consumer side,
  // <q>_full/<q>_wr/<q>_data on the producer side.
  typedef struct packed {
    logic empty;
    logic rd;
  } q_rd_ctrl_t;

endpackage

// File: rtl/kpn_sat_adder.sv
// rtl/kpn_sat_adder.sv - combinational adder with optional all-ones clamp on carry-out
module kpn_sat_adder #(
  parameter int DATA_W   = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  logic [DATA_W:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign carry    = full_sum[DATA_W];
  assign sum      = (SATURATE && carry) ? {DATA_W{1'b1}} : full_sum[DATA_W-1:0];

endmodule

// File: rtl/kpn_adder_process.sv
// rtl/kpn_adder_process.sv - KPN node: pops one token from each of two queues, pushes their sum
module kpn_adder_process
  import kpn_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SATURATE = 0,
  parameter int COUNT_W  = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               a_empty,
  output logic               a_rd,
  input  logic [DATA_W-1:0]  a_data,
  input  logic               b_empty,
  output logic               b_rd,
  input  logic [DATA_W-1:0]  b_data,
  input  logic               out_full,
  output logic               out_wr,
  output logic [DATA_W-1:0]  out_data,
  output logic               overflow,
  output logic [COUNT_W-1:0] token_count,
  output logic               busy
);

  node_state_t       state;
  logic [DATA_W-1:0] sum;
  logic              carry;

  kpn_sat_adder #(
    .DATA_W   (DATA_W),
    .SATURATE (SATURATE != 0)
  ) u_adder (
    .a     (a_data),
    .b     (b_data),
    .sum   (sum),
    .carry (carry)
  );

  // Strobes are gated by reset so an aborted transaction never touches a queue
  assign a_rd   = (state == ST_READ) && !reset;
  assign b_rd   = (state == ST_READ) && !reset;
  assign out_wr = (state == ST_WRITE) && !out_full && !reset;
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      out_data    <= '0;
      overflow    <= 1'b0;
      token_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!a_empty && !b_empty) state <= ST_READ;
        end
        ST_READ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          out_data <= sum;
          if (carry) overflow <= 1'b1;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (!out_full) begin
            token_count <= token_count + 1'b1;
            state       <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kpn_adder_process.sv
// tb/tb_kpn_adder_process.sv - directed self-checking bench for kpn_adder_process
module tb_kpn_adder_process;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_empty, b_empty, out_full;
  logic [15:0] a_data, b_data;

  logic        a_rd0, b_rd0, out_wr0, overflow0, busy0;
  logic [15:0] out_data0;
  logic [7:0]  token_count0;
  logic        a_rd1, b_rd1, out_wr1, overflow1, busy1;
  logic [15:0] out_data1;
  logic [7:0]  token_count1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_cnt;
  logic        exp_ovf;

  always #5 clk = ~clk;

  kpn_adder_process #(.DATA_W(16), .SATURATE(0), .COUNT_W(8)) dut0 (
    .clk(clk), .reset(reset),
    .a_empty(a_empty), .a_rd(a_rd0), .a_data(a_data),
    .b_empty(b_empty), .b_rd(b_rd0), .b_data(b_data),
    .out_full(out_full), .out_wr(out_wr0), .out_data(out_data0),
    .overflow(overflow0), .token_count(token_count0), .busy(busy0)
  );

  kpn_adder_process #(.DATA_W(16), .SATURATE(1), .COUNT_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .a_empty(a_empty), .a_rd(a_rd1), .a_data(a_data),
    .b_empty(b_empty), .b_rd(b_rd1), .b_data(b_data),
    .out_full(out_full), .out_wr(out_wr1), .out_data(out_data1),
    .overflow(overflow1), .token_count(token_count1), .busy(busy1)
  );

  // Lands just after a falling edge: inputs may be driven here for the next rising edge
  task automatic adv();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; a_empty = 1'b0; b_empty = 1'b0; out_full = 1'b0;
    a_data = 16'h0003; b_data = 16'h0004;
    for (int i = 0; i < 2; i++) begin
      adv();
      n_cmp++;
      if ({a_rd0, b_rd0, out_wr0, a_rd1, b_rd1, out_wr1} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_strobes: got %b want 000000",
                 {a_rd0, b_rd0, out_wr0, a_rd1, b_rd1, out_wr1});
      end
      n_cmp++;
      if ({busy0, overflow0, out_data0, token_count0, busy1, overflow1, out_data1, token_count1} !== 52'h0) begin
        n_bad++;
        $display("FAIL reset_outputs: got busy=%b ovf=%b data=%h cnt=%0d / busy=%b ovf=%b data=%h cnt=%0d want all 0",
                 busy0, overflow0, out_data0, token_count0, busy1, overflow1, out_data1, token_count1);
      end
    end
    a_empty = 1'b1; b_empty = 1'b1;
    reset = 1'b0;
    exp_cnt = 8'd0;
    exp_ovf = 1'b0;
  endtask

  task automatic test_token(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp0, input logic [15:0] exp1, input logic carry);
    a_data = a; b_data = b; a_empty = 1'b0; b_empty = 1'b0; out_full = 1'b0;
    adv();
    n_cmp++;
    if ({a_rd0, b_rd0, a_rd1, b_rd1, busy0} !== 5'b11111) begin
      n_bad++;
      $display("FAIL %s_rd: got rd/busy %b want 11111", name, {a_rd0, b_rd0, a_rd1, b_rd1, busy0});
    end
    a_empty = 1'b1; b_empty = 1'b1;
    adv();
    n_cmp++;
    if ({a_rd0, b_rd0, out_wr0, a_rd1, b_rd1, out_wr1} !== 6'b0) begin
      n_bad++;
      $display("FAIL %s_wait: got strobes %b want 000000", name, {a_rd0, b_rd0, out_wr0, a_rd1, b_rd1, out_wr1});
    end
    adv();
    n_cmp++;
    if ({out_wr0, out_wr1} !== 2'b11) begin
      n_bad++;
      $display("FAIL %s_wr: got out_wr %b want 11", name, {out_wr0, out_wr1});
    end
    n_cmp++;
    if (out_data0 !== exp0 || out_data1 !== exp1) begin
      n_bad++;
      $display("FAIL %s_data: got %h/%h want %h/%h", name, out_data0, out_data1, exp0, exp1);
    end
    exp_cnt = exp_cnt + 8'd1;
    if (carry) exp_ovf = 1'b1;
    adv();
    n_cmp++;
    if (token_count0 !== exp_cnt || token_count1 !== exp_cnt || busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_count: got cnt %0d/%0d busy %b want cnt %0d busy 0",
               name, token_count0, token_count1, busy0, exp_cnt);
    end
    n_cmp++;
    if ({overflow0, overflow1} !== {exp_ovf, exp_ovf}) begin
      n_bad++;
      $display("FAIL %s_ovf: got %b want %b", name, {overflow0, overflow1}, {exp_ovf, exp_ovf});
    end
  endtask

  task automatic test_asymmetric_empty();
    a_empty = 1'b0; b_empty = 1'b1; a_data = 16'h0005; b_data = 16'h0006;
    for (int i = 0; i < 10; i++) begin
      adv();
      n_cmp++;
      if ({a_rd0, b_rd0, busy0, a_rd1, b_rd1, busy1} !== 6'b0) begin
        n_bad++;
        $display("FAIL asym_idle cycle %0d: got rd/busy %b want 000000", i, {a_rd0, b_rd0, busy0, a_rd1, b_rd1, busy1});
      end
    end
    b_empty = 1'b0;
    adv();
    n_cmp++;
    if ({a_rd0, b_rd0} !== 2'b11) begin
      n_bad++;
      $display("FAIL asym_pop: got rd %b want 11", {a_rd0, b_rd0});
    end
    a_empty = 1'b1; b_empty = 1'b1;
    adv();
    adv();
    n_cmp++;
    if (out_wr0 !== 1'b1 || out_data0 !== 16'h000B) begin
      n_bad++;
      $display("FAIL asym_wr: got wr=%b data=%h want wr=1 data=000b", out_wr0, out_data0);
    end
    exp_cnt = exp_cnt + 8'd1;
    adv();
  endtask

  task automatic test_backpressure();
    a_data = 16'h1234; b_data = 16'h0101; a_empty = 1'b0; b_empty = 1'b0; out_full = 1'b1;
    adv();
    a_empty = 1'b1; b_empty = 1'b1;
    adv();
    adv();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if ({out_wr0, out_wr1} !== 2'b00 || out_data0 !== 16'h1335 || busy0 !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: got wr=%b data=%h busy=%b want wr=00 data=1335 busy=1",
                 i, {out_wr0, out_wr1}, out_data0, busy0);
      end
      adv();
    end
    out_full = 1'b0;
    #1;
    n_cmp++;
    if ({out_wr0, out_wr1} !== 2'b11 || out_data0 !== 16'h1335) begin
      n_bad++;
      $display("FAIL bp_release: got wr=%b data=%h want wr=11 data=1335", {out_wr0, out_wr1}, out_data0);
    end
    exp_cnt = exp_cnt + 8'd1;
    adv();
    n_cmp++;
    if (out_wr0 !== 1'b0 || token_count0 !== exp_cnt) begin
      n_bad++;
      $display("FAIL bp_single: got wr=%b cnt=%0d want wr=0 cnt=%0d", out_wr0, token_count0, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta, tb, ts;
    logic        wrapped;
    wrapped = 1'b0;
    out_full = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ta = 16'(i * 3);
      tb = 16'(i * 7);
      ts = 16'(i * 10);
      a_data = ta; b_data = tb; a_empty = 1'b0; b_empty = 1'b0;
      adv();
      n_cmp++;
      if ({a_rd0, b_rd0} !== 2'b11) begin
        n_bad++;
        $display("FAIL stream_rd pair %0d: got %b want 11", i, {a_rd0, b_rd0});
      end
      adv();
      adv();
      n_cmp++;
      if (out_wr0 !== 1'b1 || out_data0 !== ts || out_data1 !== ts) begin
        n_bad++;
        $display("FAIL stream_wr pair %0d: got wr=%b data=%h/%h want wr=1 data=%h", i, out_wr0, out_data0, out_data1, ts);
      end
      if (exp_cnt == 8'hFF) wrapped = 1'b1;
      exp_cnt = exp_cnt + 8'd1;
      adv();
      n_cmp++;
      if (token_count0 !== exp_cnt || token_count1 !== exp_cnt) begin
        n_bad++;
        $display("FAIL stream_count pair %0d: got %0d/%0d want %0d", i, token_count0, token_count1, exp_cnt);
      end
    end
    a_empty = 1'b1; b_empty = 1'b1;
    n_cmp++;
    if (wrapped !== 1'b1 || token_count0 !== 8'd49) begin
      n_bad++;
      $display("FAIL stream_wrap: got cnt=%0d wrapped=%b want cnt=49 wrapped=1", token_count0, wrapped);
    end
    adv();
  endtask

  task automatic test_midop_reset();
    a_data = 16'hFFFF; b_data = 16'h0001; a_empty = 1'b0; b_empty = 1'b0; out_full = 1'b0;
    adv();
    a_empty = 1'b1; b_empty = 1'b1;
    adv();
    reset = 1'b1;
    adv();
    n_cmp++;
    if ({busy0, out_wr0, overflow0, busy1, out_wr1, overflow1} !== 6'b0 ||
        token_count0 !== 8'd0 || out_data0 !== 16'h0) begin
      n_bad++;
      $display("FAIL midop_reset_wait: got busy=%b wr=%b ovf=%b cnt=%0d data=%h want all 0",
               busy0, out_wr0, overflow0, token_count0, out_data0);
    end
    reset = 1'b0;
    exp_cnt = 8'd0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adv();
      n_cmp++;
      if ({out_wr0, out_wr1, busy0} !== 3'b0) begin
        n_bad++;
        $display("FAIL midop_after cycle %0d: got wr/busy %b want 000", i, {out_wr0, out_wr1, busy0});
      end
    end
    a_empty = 1'b0; b_empty = 1'b0;
    adv();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_rd0, b_rd0, a_rd1, b_rd1} !== 4'b0) begin
      n_bad++;
      $display("FAIL midop_reset_read: got rd %b want 0000 during reset cycle", {a_rd0, b_rd0, a_rd1, b_rd1});
    end
    a_empty = 1'b1; b_empty = 1'b1;
    adv();
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL midop_reset_read_idle: got busy=%b want 0", busy0);
    end
    reset = 1'b0;
    adv();
  endtask

  initial begin
    test_reset();
    test_token("basic", 16'h0003, 16'h0004, 16'h0007, 16'h0007, 1'b0);
    test_asymmetric_empty();
    test_token("wrap", 16'hFFFF, 16'h0002, 16'h0001, 16'hFFFF, 1'b1);
    test_token("sticky", 16'h000A, 16'h0014, 16'h001E, 16'h001E, 1'b0);
    test_backpressure();
    test_back_to_back();
    test_midop_reset();
    test_token("recover", 16'h0003, 16'h0004, 16'h0007, 16'h0007, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
